// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_pkg
//  Purpose  : Shared digit types, limits and FSM encoding for BCD conversion.
//  Revision : 1.0  initial release
// ============================================================================
package bcd_pkg;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX     = 4'd9;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_t;

    function automatic logic isInvalid(input bcd_digit_t d);
        return d > BCD_MAX;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_mac10.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_mac10
//  Purpose  : Combinational acc*10 + digit with carry-out detection.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_mac10
    import bcd_pkg::*;
#(
    parameter int BINARY_WIDTH = 32
) (
    input  logic [BINARY_WIDTH-1:0] acc,
    input  bcd_digit_t              digit,
    output logic [BINARY_WIDTH-1:0] result,
    output logic                    overflow
);

    // Four guard bits hold the largest product (acc_max*10 + 15) exactly.
    logic [BINARY_WIDTH+3:0] w_acc;
    logic [BINARY_WIDTH+3:0] w_sum;

    assign w_acc    = {4'b0000, acc};
    assign w_sum    = (w_acc << 3) + (w_acc << 1) + {{BINARY_WIDTH{1'b0}}, digit};
    assign result   = w_sum[BINARY_WIDTH-1:0];
    assign overflow = |w_sum[BINARY_WIDTH+3:BINARY_WIDTH];

endmodule
`default_nettype wire

// File: rtl/bcd_to_binary_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_to_binary_seq
//  Purpose  : Iterative BCD-to-binary converter, one digit per clock, MSD first.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter int BINARY_WIDTH = 32,
    parameter int NUM_DIGITS   = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load,
    input  logic [NUM_DIGITS-1:0][3:0]       bcd_in,
    output logic                             busy,
    output logic                             done,
    output logic [BINARY_WIDTH-1:0]          binary_out,
    output logic                             invalid,
    output logic                             overflow
);

    localparam int DIG_W = NUM_DIGITS * BCD_DIGIT_W;
    localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    conv_state_t             r_state;
    logic [DIG_W-1:0]        r_digits;
    logic [BINARY_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_inv;
    logic                    r_ovf;

    bcd_digit_t              w_top;
    logic [BINARY_WIDTH-1:0] w_sum;
    logic                    w_ovf;
    logic                    w_accept;
    logic                    w_topInv;

    assign w_top    = r_digits[DIG_W-1 -: BCD_DIGIT_W];
    assign w_topInv = isInvalid(w_top);
    assign w_accept = load && (r_state != CONV);

    bcd_mac10 #(
        .BINARY_WIDTH (BINARY_WIDTH)
    ) u_mac (
        .acc      (r_acc),
        .digit    (w_top),
        .result   (w_sum),
        .overflow (w_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_digits   <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_inv      <= 1'b0;
            r_ovf      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            binary_out <= '0;
            invalid    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_accept) begin
                // A load in the DONE cycle restarts immediately; the done pulse still shows.
                r_state  <= CONV;
                r_digits <= bcd_in;
                r_acc    <= '0;
                r_cnt    <= CNT_W'(NUM_DIGITS - 1);
                r_inv    <= 1'b0;
                r_ovf    <= 1'b0;
                busy     <= 1'b1;
            end else begin
                case (r_state)
                    CONV: begin
                        r_acc    <= w_sum;
                        r_digits <= r_digits << BCD_DIGIT_W;
                        r_cnt    <= r_cnt - CNT_W'(1);
                        r_inv    <= r_inv | w_topInv;
                        r_ovf    <= r_ovf | w_ovf;
                        if (r_cnt == '0) begin
                            r_state    <= DONE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            binary_out <= w_sum;
                            invalid    <= r_inv | w_topInv;
                            overflow   <= r_ovf | w_ovf;
                        end
                    end
                    DONE:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
